// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer-side signal bundle for sync_fifo_prog.
// The FIFO takes the slave modport; the environment driving it takes master.
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty levels and occupancy count.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 7,
    parameter int AE_LEVEL   = 1
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_prog_if.slave   fif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  full_w, empty_w;
    logic                  wr_acc, rd_acc;

    assign full_w  = (count_q == CW'(FIFO_DEPTH));
    assign empty_w = (count_q == '0);

    // Acceptance is decided on the pre-edge count, so a full FIFO still
    // drains on a simultaneous read and an empty one still fills.
    always_comb begin
        wr_acc   = fif.wr_en && !full_w;
        rd_acc   = fif.rd_en && !empty_w;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= fif.wr_en && full_w;
            underflow_q <= fif.rd_en && empty_w;
        end
    end

    // Storage is deliberately left out of reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= fif.data_in;
    end

`ifdef FIFO_FWFT_EN
    assign fif.data_out = empty_w ? '0 : mem_q[rd_ptr_q];
`else
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout_q <= '0;
        else if (rd_acc)
            dout_q <= mem_q[rd_ptr_q];
    end

    assign fif.data_out = dout_q;
`endif

    assign fif.wr_ack      = wr_ack_q;
    assign fif.overflow    = overflow_q;
    assign fif.underflow   = underflow_q;
    assign fif.full        = full_w;
    assign fif.empty       = empty_w;
    assign fif.almostfull  = (count_q >= CW'(AF_LEVEL));
    assign fif.almostempty = !empty_w && (count_q <= CW'(AE_LEVEL));
    assign fif.count       = count_q;

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(FIFO_DEPTH));
    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (rst)
        !(wr_ack_q && overflow_q));
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: stimulus pushes expected post-edge state into
// per-DUT queues, negedge monitors pop and compare. Covers DEPTH=8 and DEPTH=5 instances.
module tb_sync_fifo_prog;
    typedef struct {
        logic        wr_ack, ovf, udf;
        logic [3:0]  cnt;
        logic        full, empty, af, ae;
        logic [15:0] dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] douta = '0;
    logic [15:0] doutb = '0;
    exp_t        expa[$];
    exp_t        expb[$];
    exp_t        ea, eb;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) fa();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) fb();

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1))
        u_a (.clk(clk), .rst(rst), .fif(fa));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2))
        u_b (.clk(clk), .rst(rst), .fif(fb));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: a plain queue plus the read-data register.
    function automatic void model_step(inout logic [15:0] q[$], inout logic [15:0] dout,
                                       input int depth, input int afl, input int ael,
                                       input bit wr, input bit rd, input logic [15:0] d,
                                       output exp_t e);
        int n = q.size();
        bit wa = wr && (n != depth);
        bit ra = rd && (n != 0);
        logic [15:0] pv;
        if (ra) begin
            pv = q.pop_front();
`ifndef FIFO_FWFT_EN
            dout = pv;
`endif
        end
        if (wa) q.push_back(d);
        n        = q.size();
        e.wr_ack = wa;
        e.ovf    = wr && !wa;
        e.udf    = rd && !ra;
        e.cnt    = 4'(n);
        e.full   = (n == depth);
        e.empty  = (n == 0);
        e.af     = (n >= afl);
        e.ae     = (n != 0) && (n <= ael);
`ifdef FIFO_FWFT_EN
        e.dout   = (n != 0) ? q[0] : 16'h0;
`else
        e.dout   = dout;
`endif
    endfunction

    task automatic step_a(input bit wr, input bit rd, input logic [15:0] d);
        exp_t e;
        fa.wr_en = wr; fa.rd_en = rd; fa.data_in = d;
        @(posedge clk);
        model_step(qa, douta, 8, 7, 1, wr, rd, d, e);
        expa.push_back(e);
        #1;
        fa.wr_en = 1'b0; fa.rd_en = 1'b0;
    endtask

    task automatic step_b(input bit wr, input bit rd, input logic [15:0] d);
        exp_t e;
        fb.wr_en = wr; fb.rd_en = rd; fb.data_in = d;
        @(posedge clk);
        model_step(qb, doutb, 5, 4, 2, wr, rd, d, e);
        expb.push_back(e);
        #1;
        fb.wr_en = 1'b0; fb.rd_en = 1'b0;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        douta = '0; doutb = '0;
    endtask

    always @(negedge clk) begin
        if (expa.size() > 0) begin
            ea = expa.pop_front();
            chk("A.wr_ack", 32'(fa.wr_ack), 32'(ea.wr_ack));
            chk("A.overflow", 32'(fa.overflow), 32'(ea.ovf));
            chk("A.underflow", 32'(fa.underflow), 32'(ea.udf));
            chk("A.count", 32'(fa.count), 32'(ea.cnt));
            chk("A.full", 32'(fa.full), 32'(ea.full));
            chk("A.empty", 32'(fa.empty), 32'(ea.empty));
            chk("A.almostfull", 32'(fa.almostfull), 32'(ea.af));
            chk("A.almostempty", 32'(fa.almostempty), 32'(ea.ae));
            chk("A.data_out", 32'(fa.data_out), 32'(ea.dout));
        end
        if (expb.size() > 0) begin
            eb = expb.pop_front();
            chk("B.wr_ack", 32'(fb.wr_ack), 32'(eb.wr_ack));
            chk("B.overflow", 32'(fb.overflow), 32'(eb.ovf));
            chk("B.underflow", 32'(fb.underflow), 32'(eb.udf));
            chk("B.count", 32'(fb.count), 32'(eb.cnt));
            chk("B.full", 32'(fb.full), 32'(eb.full));
            chk("B.empty", 32'(fb.empty), 32'(eb.empty));
            chk("B.almostfull", 32'(fb.almostfull), 32'(eb.af));
            chk("B.almostempty", 32'(fb.almostempty), 32'(eb.ae));
            chk("B.data_out", 32'(fb.data_out), 32'(eb.dout));
        end
    end

    int opsb[] = '{1,1,1,1,1,3,2,2,3,3,2,2,1,3,3,2,2,2,1,1,2,2};

    initial begin
        logic [15:0] nb;
        fa.wr_en = 0; fa.rd_en = 0; fa.data_in = '0;
        fb.wr_en = 0; fb.rd_en = 0; fb.data_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Reset state
        chk("rst.empty", 32'(fa.empty), 32'd1);
        chk("rst.count", 32'(fa.count), 32'd0);
        chk("rst.full", 32'(fa.full), 32'd0);
        chk("rst.almostempty", 32'(fa.almostempty), 32'd0);
        chk("rst.almostfull", 32'(fa.almostfull), 32'd0);
        chk("rst.data_out", 32'(fa.data_out), 32'd0);
        chk("rst.strobes", 32'({fa.wr_ack, fa.overflow, fa.underflow}), 32'd0);
        chk("rstB.empty", 32'(fb.empty), 32'd1);

        // Fill to full, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            step_a(1, 0, 16'hA000 + 16'(i));
            if (i == 7) chk("fill.af_at7", 32'(fa.almostfull), 32'd1);
            if (i == 6) chk("fill.af_at6", 32'(fa.almostfull), 32'd0);
        end
        chk("fill.full", 32'(fa.full), 32'd1);
        chk("fill.count8", 32'(fa.count), 32'd8);
        step_a(1, 0, 16'hDEAD);
        chk("fill.overflow", 32'(fa.overflow), 32'd1);
        chk("fill.no_ack", 32'(fa.wr_ack), 32'd0);

        // Drain in order, then one rejected read
        for (int i = 1; i <= 8; i++) begin
            step_a(0, 1, '0);
`ifndef FIFO_FWFT_EN
            chk("drain.data", 32'(fa.data_out), 32'(16'hA000 + 16'(i)));
`endif
        end
        step_a(0, 1, '0);
        chk("drain.underflow", 32'(fa.underflow), 32'd1);
        chk("drain.empty", 32'(fa.empty), 32'd1);
`ifndef FIFO_FWFT_EN
        chk("drain.hold", 32'(fa.data_out), 32'hA008);
`endif

        // Simultaneous requests at full and at empty
        for (int i = 1; i <= 8; i++) step_a(1, 0, 16'hA000 + 16'(i));
        step_a(1, 1, 16'hBEEF);
        chk("full_rw.overflow", 32'(fa.overflow), 32'd1);
        chk("full_rw.count", 32'(fa.count), 32'd7);
`ifndef FIFO_FWFT_EN
        chk("full_rw.data", 32'(fa.data_out), 32'hA001);
`endif
        for (int i = 0; i < 7; i++) step_a(0, 1, '0);
        step_a(1, 1, 16'hC0DE);
        chk("empty_rw.wr_ack", 32'(fa.wr_ack), 32'd1);
        chk("empty_rw.underflow", 32'(fa.underflow), 32'd1);
        chk("empty_rw.count", 32'(fa.count), 32'd1);
        step_a(0, 1, '0);

        // Asynchronous reset mid-stream at count=3
        for (int i = 0; i < 3; i++) step_a(1, 0, 16'h5500 + 16'(i));
        chk("mid.count3", 32'(fa.count), 32'd3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst.count", 32'(fa.count), 32'd0);
        chk("mid_rst.empty", 32'(fa.empty), 32'd1);
        chk("mid_rst.data_out", 32'(fa.data_out), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word into an empty FIFO, observed without and then with a read
        step_a(1, 0, 16'h1234);
        step_a(0, 0, '0);
`ifdef FIFO_FWFT_EN
        chk("fwft.show", 32'(fa.data_out), 32'h1234);
`else
        chk("std.no_read", 32'(fa.data_out), 32'h0);
`endif
        step_a(0, 1, '0);
        chk("pop.empty", 32'(fa.empty), 32'd1);
`ifdef FIFO_FWFT_EN
        chk("fwft.pop_zero", 32'(fa.data_out), 32'h0);
`else
        chk("std.pop_data", 32'(fa.data_out), 32'h1234);
`endif

        // DEPTH=5 instance: interleaved traffic wraps both pointers
        nb = 16'hB000;
        foreach (opsb[i]) begin
            step_b(opsb[i][0], opsb[i][1], nb);
            if (opsb[i][0]) nb = nb + 16'd1;
            if (i == 3) chk("B.af_at4", 32'(fb.almostfull), 32'd1);
            if (i == 2) chk("B.ae_off_at3", 32'(fb.almostempty), 32'd0);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
